// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a single-port synchronous SRAM macro.
// Byte-lane writes, single-cycle reads, one wait state when a read lands on a write data phase.
module ahb_sram_slave #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [3:0]  sram_ben,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_ERR1    = 3'd4;
    localparam logic [2:0] ST_ERR2    = 3'd5;

    localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;

    logic [2:0]  state, state_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [3:0]  ben_q, ben_nxt;

    logic [31:0] off;
    logic [31:0] word_idx;
    logic [3:0]  ben_dec;
    logic        in_range, size_ok, align_ok, legal, accept, ready;
    logic        unused_ok;

    assign off       = HADDR - BASE_ADDR;
    assign word_idx  = {2'b00, off[31:2]};
    assign in_range  = (HADDR >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
    assign unused_ok = ^{HTRANS[0], off[1:0]};

    always_comb begin
        size_ok  = 1'b1;
        align_ok = 1'b1;
        ben_dec  = '0;
        case (HSIZE)
            3'b000: ben_dec = 4'b0001 << HADDR[1:0];
            3'b001: begin
                align_ok = ~HADDR[0];
                ben_dec  = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                align_ok = (HADDR[1:0] == 2'b00);
                ben_dec  = '1;
            end
            default: size_ok = 1'b0;
        endcase
    end

    // Reset also masks acceptance so a live bus request cannot reach the SRAM pins.
    assign accept = HSEL & HTRANS[1] & HREADY & ~HRESET;
    assign legal  = in_range & size_ok & align_ok;
    assign ready  = (state != ST_RD_WAIT) && (state != ST_ERR1);

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        ben_nxt   = ben_q;
        case (state)
            ST_RD_WAIT: state_nxt = ST_RD;
            ST_ERR1:    state_nxt = ST_ERR2;
            default: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_nxt = ST_ERR1;
                    end else if (HWRITE) begin
                        state_nxt = ST_WR;
                        addr_nxt  = word_idx;
                        ben_nxt   = ben_dec;
                    end else if (state == ST_WR) begin
                        state_nxt = ST_RD_WAIT;
                        addr_nxt  = word_idx;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            ben_q  <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            ben_q  <= ben_nxt;
        end
    end

    // Write data phase owns the port; a colliding read is replayed from addr_q in RD_WAIT.
    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = '0;
        sram_addr = '0;
        sram_din  = '0;
        if (state == ST_WR) begin
            sram_cen  = 1'b0;
            sram_wen  = 1'b0;
            sram_ben  = ben_q;
            sram_addr = addr_q;
            sram_din  = HWDATA;
        end else if (state == ST_RD_WAIT) begin
            sram_cen  = 1'b0;
            sram_addr = addr_q;
        end else if (ready && accept && legal && !HWRITE) begin
            sram_cen  = 1'b0;
            sram_addr = word_idx;
        end
    end

    assign HREADYOUT = ready;
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
    assign HRDATA    = (state == ST_RD) ? sram_dout : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave with a behavioural single-port SRAM model.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    logic        fill;
    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    ahb_sram_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: HREADY is the slave's own HREADYOUT.
    assign HREADY = HREADYOUT;

    // Word i starts as 0x1000_0000 + i.
    always @(posedge HCLK) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (!sram_cen) begin
            if (!sram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (sram_ben[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= mem[sram_addr[7:0]];
            end
        end
    end

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic [2:0] size);
        HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
    endtask

    task automatic idle_bus();
        drive(1'b0, T_IDLE, 32'h0, 1'b0, SZ_W);
    endtask

    task automatic next_cycle();
        @(posedge HCLK); #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESET = 1'b1; fill = 1'b1; HWDATA = 32'h0;
        drive(1'b1, T_NONSEQ, 32'h0, 1'b0, SZ_W);
        sample();
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %b exp 1", HREADYOUT); end
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL rst_hresp got %b exp 00", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", HRDATA); end
        checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL rst_cen got %b exp 1", sram_cen); end
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL rst_wen got %b exp 1", sram_wen); end
        checks++; if (sram_ben !== 4'b0) begin errors++; $display("FAIL rst_ben got %b exp 0000", sram_ben); end
        checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", sram_addr); end
        checks++; if (sram_din !== 32'h0) begin errors++; $display("FAIL rst_din got %h exp 0", sram_din); end
        next_cycle();
        next_cycle();
        fill = 1'b0; HRESET = 1'b0; idle_bus();
        next_cycle();
        // Write to 0x20 abandoned by reset during its data phase.
        drive(1'b1, T_NONSEQ, 32'h20, 1'b1, SZ_W);
        next_cycle();
        HWDATA = 32'h1234_5678; idle_bus();
        #1 HRESET = 1'b1;
        #1;
        checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL midrst_cen got %b exp 1", sram_cen); end
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL midrst_wen got %b exp 1", sram_wen); end
        checks++; if (sram_din !== 32'h0) begin errors++; $display("FAIL midrst_din got %h exp 0", sram_din); end
        checks++; if (sram_ben !== 4'b0) begin errors++; $display("FAIL midrst_ben got %b exp 0000", sram_ben); end
        checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h exp 0", sram_addr); end
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL midrst_hreadyout got %b exp 1", HREADYOUT); end
        next_cycle();
        HRESET = 1'b0;
        drive(1'b1, T_IDLE, 32'h0, 1'b0, SZ_W);
        next_cycle();
        drive(1'b1, T_NONSEQ, 32'h20, 1'b0, SZ_W);
        sample();
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL idle_hreadyout got %b exp 1", HREADYOUT); end
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL idle_hresp got %b exp 00", HRESP); end
        checks++; if ({sram_cen, sram_wen} !== 2'b01) begin errors++; $display("FAIL rdissue_cenwen got %b exp 01", {sram_cen, sram_wen}); end
        checks++; if (sram_addr !== 32'd8) begin errors++; $display("FAIL rdissue_addr got %h exp 8", sram_addr); end
        next_cycle();
        idle_bus();
        sample();
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rd0w_hreadyout got %b exp 1", HREADYOUT); end
        checks++; if (HRDATA !== 32'h1000_0008) begin errors++; $display("FAIL abandoned_wr got %h exp 10000008", HRDATA); end
        next_cycle();
    endtask

    task automatic test_write_read();
        drive(1'b1, T_NONSEQ, 32'h10, 1'b1, SZ_W);
        next_cycle();
        HWDATA = 32'hDEAD_BEEF;
        drive(1'b1, T_NONSEQ, 32'h10, 1'b0, SZ_W);
        sample();
        checks++; if ({sram_cen, sram_wen} !== 2'b00) begin errors++; $display("FAIL wr_cenwen got %b exp 00", {sram_cen, sram_wen}); end
        checks++; if (sram_ben !== 4'b1111) begin errors++; $display("FAIL wr_ben got %b exp 1111", sram_ben); end
        checks++; if (sram_addr !== 32'd4) begin errors++; $display("FAIL wr_addr got %h exp 4", sram_addr); end
        checks++; if (sram_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_din got %h exp deadbeef", sram_din); end
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL wr_hreadyout got %b exp 1", HREADYOUT); end
        next_cycle();
        idle_bus();
        sample();
        checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL rdwait_hreadyout got %b exp 0", HREADYOUT); end
        checks++; if ({sram_cen, sram_wen} !== 2'b01) begin errors++; $display("FAIL rdwait_cenwen got %b exp 01", {sram_cen, sram_wen}); end
        checks++; if (sram_addr !== 32'd4) begin errors++; $display("FAIL rdwait_addr got %h exp 4", sram_addr); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rdwait_hrdata got %h exp 0", HRDATA); end
        next_cycle();
        sample();
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL raw_hreadyout got %b exp 1", HREADYOUT); end
        checks++; if (HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_hrdata got %h exp deadbeef", HRDATA); end
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL raw_hresp got %b exp 00", HRESP); end
        next_cycle();
        sample();
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL idle_hrdata got %h exp 0", HRDATA); end
        next_cycle();
    endtask

    task automatic test_byte_half();
        drive(1'b1, T_NONSEQ, 32'h13, 1'b1, SZ_B);
        next_cycle();
        HWDATA = 32'hAA00_0000;
        drive(1'b1, T_NONSEQ, 32'h16, 1'b1, SZ_H);
        sample();
        checks++; if (sram_ben !== 4'b1000) begin errors++; $display("FAIL byte_ben got %b exp 1000", sram_ben); end
        checks++; if (sram_din !== 32'hAA00_0000) begin errors++; $display("FAIL byte_din got %h exp aa000000", sram_din); end
        checks++; if (sram_addr !== 32'd4) begin errors++; $display("FAIL byte_addr got %h exp 4", sram_addr); end
        next_cycle();
        HWDATA = 32'h5566_0000;
        drive(1'b1, T_NONSEQ, 32'h10, 1'b0, SZ_W);
        sample();
        checks++; if (sram_ben !== 4'b1100) begin errors++; $display("FAIL half_ben got %b exp 1100", sram_ben); end
        checks++; if (sram_addr !== 32'd5) begin errors++; $display("FAIL half_addr got %h exp 5", sram_addr); end
        checks++; if ({HREADYOUT, sram_wen} !== 2'b10) begin errors++; $display("FAIL b2bwr_ready_wen got %b exp 10", {HREADYOUT, sram_wen}); end
        next_cycle();
        drive(1'b1, T_NONSEQ, 32'h14, 1'b0, SZ_W);
        sample();
        checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL byte_rdwait got %b exp 0", HREADYOUT); end
        checks++; if (sram_addr !== 32'd4) begin errors++; $display("FAIL byte_rdwait_addr got %h exp 4", sram_addr); end
        next_cycle();
        sample();
        checks++; if (HRDATA !== 32'hAAAD_BEEF) begin errors++; $display("FAIL byte_rd got %h exp aaadbeef", HRDATA); end
        checks++; if ({sram_cen, sram_addr} !== {1'b0, 32'd5}) begin errors++; $display("FAIL rd_in_rd got %h exp 0_00000005", {sram_cen, sram_addr}); end
        next_cycle();
        idle_bus();
        sample();
        checks++; if (HRDATA !== 32'h5566_0005) begin errors++; $display("FAIL half_rd got %h exp 55660005", HRDATA); end
        next_cycle();
    endtask

    task automatic test_range();
        drive(1'b1, T_NONSEQ, 32'h3FC, 1'b0, SZ_W);
        sample();
        checks++; if ({sram_cen, sram_addr} !== {1'b0, 32'hFF}) begin errors++; $display("FAIL last_word_issue got %h exp 0_000000ff", {sram_cen, sram_addr}); end
        next_cycle();
        drive(1'b1, T_NONSEQ, 32'h400, 1'b0, SZ_W);
        sample();
        checks++; if (HRDATA !== 32'h1000_00FF) begin errors++; $display("FAIL last_word_rd got %h exp 100000ff", HRDATA); end
        checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL oor_issue_cen got %b exp 1", sram_cen); end
        next_cycle();
        idle_bus();
        sample();
        checks++; if ({HREADYOUT, HRESP} !== 3'b001) begin errors++; $display("FAIL oor_err1 got %b exp 001", {HREADYOUT, HRESP}); end
        checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL oor_err1_cen got %b exp 1", sram_cen); end
        next_cycle();
        drive(1'b1, T_NONSEQ, 32'h400, 1'b1, SZ_W);
        sample();
        checks++; if ({HREADYOUT, HRESP} !== 3'b101) begin errors++; $display("FAIL oor_err2 got %b exp 101", {HREADYOUT, HRESP}); end
        next_cycle();
        HWDATA = 32'hFFFF_FFFF; idle_bus();
        sample();
        checks++; if ({sram_cen, HREADYOUT, HRESP} !== 4'b1001) begin errors++; $display("FAIL oor_wr_err1 got %b exp 1001", {sram_cen, HREADYOUT, HRESP}); end
        next_cycle();
        sample();
        checks++; if ({sram_cen, HREADYOUT, HRESP} !== 4'b1101) begin errors++; $display("FAIL oor_wr_err2 got %b exp 1101", {sram_cen, HREADYOUT, HRESP}); end
        next_cycle();
        sample();
        checks++; if ({HREADYOUT, HRESP} !== 3'b100) begin errors++; $display("FAIL err_to_idle got %b exp 100", {HREADYOUT, HRESP}); end
        next_cycle();
    endtask

    task automatic test_misaligned();
        drive(1'b1, T_NONSEQ, 32'h1, 1'b0, SZ_H);
        sample();
        checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL half_mis_cen got %b exp 1", sram_cen); end
        next_cycle();
        drive(1'b1, T_NONSEQ, 32'h0, 1'b0, 3'b011);
        sample();
        checks++; if ({sram_cen, HREADYOUT, HRESP} !== 4'b1001) begin errors++; $display("FAIL half_mis_err1 got %b exp 1001", {sram_cen, HREADYOUT, HRESP}); end
        next_cycle();
        sample();
        checks++; if ({sram_cen, HREADYOUT, HRESP} !== 4'b1101) begin errors++; $display("FAIL half_mis_err2 got %b exp 1101", {sram_cen, HREADYOUT, HRESP}); end
        next_cycle();
        idle_bus();
        sample();
        checks++; if ({sram_cen, HREADYOUT, HRESP} !== 4'b1001) begin errors++; $display("FAIL bad_size_err1 got %b exp 1001", {sram_cen, HREADYOUT, HRESP}); end
        next_cycle();
        sample();
        checks++; if ({sram_cen, HREADYOUT, HRESP} !== 4'b1101) begin errors++; $display("FAIL bad_size_err2 got %b exp 1101", {sram_cen, HREADYOUT, HRESP}); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, T_NONSEQ, 32'h0, 1'b0, SZ_W);
        sample();
        checks++; if ({sram_cen, sram_wen, sram_addr} !== {2'b01, 32'd0}) begin errors++; $display("FAIL b2b_issue0 got %h exp 1_00000000", {sram_cen, sram_wen, sram_addr}); end
        next_cycle();
        drive(1'b1, T_NONSEQ, 32'h4, 1'b0, SZ_W);
        sample();
        checks++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h1000_0000}) begin errors++; $display("FAIL b2b_rd0 got %h exp 1_10000000", {HREADYOUT, HRDATA}); end
        checks++; if ({sram_cen, sram_addr} !== {1'b0, 32'd1}) begin errors++; $display("FAIL b2b_issue1 got %h exp 0_00000001", {sram_cen, sram_addr}); end
        next_cycle();
        idle_bus();
        sample();
        checks++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h1000_0001}) begin errors++; $display("FAIL b2b_rd1 got %h exp 1_10000001", {HREADYOUT, HRDATA}); end
        next_cycle();
    endtask

    task automatic test_reset_rd_wait();
        drive(1'b1, T_NONSEQ, 32'h40, 1'b1, SZ_W);
        next_cycle();
        HWDATA = 32'hCAFE_F00D;
        drive(1'b1, T_NONSEQ, 32'h40, 1'b0, SZ_W);
        next_cycle();
        idle_bus();
        sample();
        checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL pre_rst_rdwait got %b exp 0", HREADYOUT); end
        HRESET = 1'b1;
        #1;
        checks++; if ({HREADYOUT, sram_cen} !== 2'b11) begin errors++; $display("FAIL rst_rdwait_ready_cen got %b exp 11", {HREADYOUT, sram_cen}); end
        next_cycle();
        HRESET = 1'b0;
        sample();
        checks++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h0}) begin errors++; $display("FAIL post_rst_no_rd got %h exp 1_00000000", {HREADYOUT, HRDATA}); end
        next_cycle();
        drive(1'b1, T_NONSEQ, 32'h40, 1'b0, SZ_W);
        next_cycle();
        idle_bus();
        sample();
        checks++; if (HRDATA !== 32'hCAFE_F00D) begin errors++; $display("FAIL post_rst_rd got %h exp cafef00d", HRDATA); end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_half();
        test_range();
        test_misaligned();
        test_back_to_back();
        test_reset_rd_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
